// File: rtl/seq_signed_divider.sv
// Sequential signed divider: restoring radix-2 division on operand magnitudes,
// one quotient bit per clock, then a sign-fix cycle; start/done handshake.
module seq_signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_ZERO = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_quo_q, sgn_quo_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;

  // Magnitude as unsigned; the most negative value maps onto 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    mag = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  assign shifted_s = {rem_q, quo_q[WIDTH-1]};
  assign diff_s    = shifted_s - {1'b0, dvs_q};

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d     = '0;
          dvs_d     = mag(divisor);
          cnt_d     = '0;
          sgn_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sgn_rem_d = dividend[WIDTH-1];
          if (divisor == '0) begin
            // Raw dividend is parked in quo_q so ZERO can return it unchanged.
            quo_d   = dividend;
            state_d = ST_ZERO;
          end else begin
            quo_d   = mag(dividend);
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        // No borrow out of the trial subtraction means shifted remainder >= divisor.
        quo_d = {quo_q[WIDTH-2:0], ~diff_s[WIDTH]};
        rem_d = diff_s[WIDTH] ? shifted_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FIX: begin
        quot_d  = sgn_quo_q ? (WIDTH'(0) - quo_q) : quo_q;
        remo_d  = sgn_rem_q ? (WIDTH'(0) - rem_q) : rem_q;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ZERO: begin
        quot_d  = '1;
        remo_d  = quo_q;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      quot_q    <= '0;
      remo_q    <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      quot_q    <= quot_d;
      remo_q    <= remo_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed-vector bench for seq_signed_divider (WIDTH=32): results, latency,
// done pulse, abort by reset, back-to-back starts, plus a short random sweep.
module tb_seq_signed_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_low_after_start", {31'd0, done}, 32'd0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er,
                     input logic ez, input int lat);
    int cyc;
    launch(a, b);
    wait_done(cyc);
    check({tag, "_lat"}, W'(cyc), W'(lat));
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    bit saw_done;
    logic [W-1:0] ra, rb, eq, er;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);

    run("p_p", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("held_q", quotient, 32'd14);
    run("n_p", -32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 33);
    run("p_n", 32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 33);
    run("n_n", -32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 33);
    run("zero_dvd", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33);
    run("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    run("min_p1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33);
    run("7_min", 32'd7, 32'h8000_0000, 32'd0, 32'd7, 1'b0, 33);
    run("m7_2", -32'sd7, 32'd2, -32'sd3, -32'sd1, 1'b0, 33);
    run("max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 33);

    run("dbz", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    @(negedge clk);
    launch(32'd9, 32'd3);
    check("start_keeps_q", quotient, 32'hFFFF_FFFF);
    check("start_keeps_dbz", {31'd0, div_by_zero}, 32'd1);
    wait_done(cyc);
    check("after_dbz_lat", W'(cyc), 32'd33);
    check("after_dbz_q", quotient, 32'd3);
    check("after_dbz_r", remainder, 32'd0);
    check("after_dbz_flag", {31'd0, div_by_zero}, 32'd0);

    // Back-to-back: second start driven during the first done cycle.
    launch(32'd100, 32'd7);
    wait_done(cyc);
    check("b2b1_q", quotient, 32'd14);
    launch(32'd1000, -32'sd10);
    wait_done(cyc);
    check("b2b2_lat", W'(cyc), 32'd33);
    check("b2b2_q", quotient, -32'sd100);
    check("b2b2_r", remainder, 32'd0);

    // Abort: ignored start while busy, then reset mid-operation.
    launch(32'd1000, 32'd10);
    repeat (3) @(negedge clk);
    dividend = 32'd7;
    divisor  = 32'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_mid", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 32'd0);
    saw_done = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    check("abort_busy_end", {31'd0, busy}, 32'd0);

    // Random sweep against Verilog signed division.
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : W'($signed(W'($urandom_range(0, 40))) - 32'sd20);
      if (rb == 32'd0 || rb == 32'hFFFF_FFFF) rb = 32'd3;
      eq = W'($signed(ra) / $signed(rb));
      er = W'($signed(ra) % $signed(rb));
      run($sformatf("rnd%0d", i), ra, rb, eq, er, 1'b0, 33);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
